muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Execute-stage multi-cycle multiply/divide unit.
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage, directly upstream of the memory stage.
- Drives a stall request that freezes fetch/decode/execute while an operation is in flight, the same way the memory stage stalls on data-bus latency.

Parameters:
- DIV_CYCLES, 32, number of radix-2 restoring-divide iterations; must equal the operand width.
- WIDTH, 32, operand and HI/LO width.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous active-high reset
- start  input  1  execute stage holds a valid muldiv instruction; held stable while busy=1
- op  input  3  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 7 treated as NONE
- src_a  input  WIDTH  rs value (dividend, multiplicand, MTHI/MTLO data)
- src_b  input  WIDTH  rt value (divisor, multiplier)
- flush  input  1  exception/redirect kill of the in-flight instruction
- busy  output  1  stall request to the pipeline control (combinational)
- done  output  1  one-cycle pulse in the cycle HI/LO are committed by MULT/DIV
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, counter=0, operand latches=0. Outputs read busy=0, done=0.
- States: IDLE, MUL, DIV.
- IDLE, start=1, op=MULT/MULTU:
  - Latch operands and signedness; next state MUL.
  - busy=1 this cycle.
- MUL (one cycle):
  - Compute the 64-bit product, signed or unsigned per latched op.
  - busy=0, done=1; at the clock edge hi=product[63:32], lo=product[31:0]; next state IDLE.
  - Total stall: 1 cycle.
- IDLE, start=1, op=DIV/DIVU:
  - Latch |src_a| and |src_b| (magnitudes for DIV, raw values for DIVU), the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - counter=0; next state DIV; busy=1.
- DIV:
  - One restoring step per cycle: shift remainder:quotient left by 1, trial-subtract the divisor, keep the result if non-negative and set the quotient LSB.
  - counter increments each cycle.
  - While counter<DIV_CYCLES-1: busy=1.
  - Cycle with counter==DIV_CYCLES-1: busy=0, done=1. The edge commits the sign-fixed results (lo=quotient, hi=remainder); next state IDLE.
  - Total stall: DIV_CYCLES cycles, i.e. 33 cycles from issue to advance.
- Divide by zero (src_b==0), DIV or DIVU:
  - Still takes the full latency.
  - Result is lo=32'hFFFF_FFFF, hi=src_a (raw), with no sign fix-up.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF under DIV: lo=0x8000_0000, hi=0. This falls out of the 32-bit magnitude arithmetic; no special case is allowed.
- MTHI/MTLO in IDLE:
  - busy=0, done=0; hi (or lo) <= src_a at the edge.
  - Single-cycle, no stall.
- start while state!=IDLE is ignored. The held instruction is still presented during the done cycle and must not re-issue.
- op=NONE or start=0 in IDLE: no state change, busy=0.
- flush=1:
  - Highest priority after reset. Next state IDLE and counter=0; hi/lo unchanged.
  - busy=0 and done=0 in that cycle.
  - A start in the same cycle as flush is dropped, including MTHI/MTLO.
- reset mid-operation: identical to flush, and additionally clears hi/lo to 0.
- hi/lo change only on a commit edge, MTHI/MTLO or reset. Forwarding of an in-flight result is not provided; the pipeline reads hi/lo only after busy falls.

Test Plan:
- MULT, src_a=0xFFFF_FFFD (-3), src_b=5 -> busy high for 1 cycle, done next cycle, then hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- MULTU, src_a=0xFFFF_FFFF, src_b=2 -> hi=0x0000_0001, lo=0xFFFF_FFFE, 1 stall cycle.
- DIV, src_a=0xFFFF_FFF9 (-7), src_b=2 -> busy high for exactly 32 cycles, done on cycle 33, then lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU, 100/0 -> full latency, lo=0xFFFF_FFFF, hi=100. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- MTHI 0x1234_5678, then MTLO 0xCAFE_0000 back-to-back -> busy never asserts, hi/lo update on consecutive edges.
- Start DIVU 50/7, assert flush at counter=10 -> busy drops that cycle, state IDLE, hi/lo keep prior values. A following MULTU 3*4 gives lo=12, hi=0. Reset at counter=5 -> hi=lo=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// Multiplies take one extra cycle; divides use a radix-2 restoring loop of
// DIV_CYCLES iterations. busy is a combinational stall request to the pipeline.
//
// Handshake: the execute stage raises start with a valid op and holds start,
// op, src_a and src_b stable for as long as busy=1. The instruction advances
// in the first cycle with busy=0; in that cycle done=1 marks the HI/LO commit
// of MULT/DIV ops. start seen outside IDLE is ignored, so the instruction still
// presented during the done cycle never re-issues. flush or reset cancel the
// in-flight op and drop any start in the same cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;      // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] b_q;      // multiplier, or divisor magnitude
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] raw_a_q;  // unmodified dividend for the divide-by-zero result
  logic             signed_q, qneg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic issue_mul, issue_div, wr_hi, wr_lo;

  // Datapath signals: product, one restoring step, sign fix-up of the result
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH:0]     rem_shift;
  logic               take;
  logic [WIDTH-1:0]   rem_next, quo_next, quo_fix, rem_fix;
  logic               div_sa, div_sb;

  // Signed/unsigned product plus one trial-subtract step of the divider
  always_comb begin
    a_ext     = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext     = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = a_ext * b_ext;
    rem_shift = {rem_q, a_q[WIDTH-1]};
    take      = (rem_shift >= {1'b0, b_q});
    // The remainder stays below the divisor, so the low WIDTH bits suffice.
    rem_next  = take ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
    quo_next  = {a_q[WIDTH-2:0], take};
    quo_fix   = dz_q ? {WIDTH{1'b1}} : (qneg_q ? -quo_next : quo_next);
    rem_fix   = dz_q ? raw_a_q       : (rneg_q ? -rem_next : rem_next);
    div_sa    = (op == OP_DIV) && src_a[WIDTH-1];
    div_sb    = (op == OP_DIV) && src_b[WIDTH-1];
  end

  // Next-state, stall and commit decode; reset and flush override everything
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    issue_mul = 1'b0;
    issue_div = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    if (reset || flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                issue_mul = 1'b1;
                busy      = 1'b1;
                state_d   = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                issue_div = 1'b1;
                busy      = 1'b1;
                state_d   = S_DIV;
              end
              OP_MTHI: wr_hi = 1'b1;
              OP_MTLO: wr_lo = 1'b1;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        S_DIV: begin
          if (cnt_q == LAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            busy = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, operand latches, divider iteration and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      raw_a_q  <= '0;
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt_q <= '0;
      end else if (issue_mul) begin
        a_q      <= src_a;
        b_q      <= src_b;
        signed_q <= (op == OP_MULT);
      end else if (issue_div) begin
        a_q      <= div_sa ? -src_a : src_a;
        b_q      <= div_sb ? -src_b : src_b;
        rem_q    <= '0;
        raw_a_q  <= src_a;
        qneg_q   <= div_sa ^ div_sb;
        rneg_q   <= div_sa;
        dz_q     <= (src_b == '0);
        cnt_q    <= '0;
      end else if (state_q == S_DIV) begin
        a_q   <= quo_next;
        rem_q <= rem_next;
        cnt_q <= cnt_q + CW'(1);
      end

      if (done && state_q == S_MUL) begin
        hi_q <= prod[2*WIDTH-1:WIDTH];
        lo_q <= prod[WIDTH-1:0];
      end else if (done && state_q == S_DIV) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end
      if (wr_hi) hi_q <= src_a;
      if (wr_lo) lo_q <= src_a;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
